// File: rtl/glyph_addr_gen.sv
// Font-bitmap bit-address generator: maps a pixel inside a scaled character cell
// to its source bit in the font bitmap using one shared serial restoring divider.
module glyph_addr_gen #(
  parameter int CHAR_W_BITS = 6,
  parameter int CHAR_H_BITS = 7,
  parameter int CHARS_BITS  = 8,
  parameter int FONT_IDX_W  = 8,
  parameter int COORD_W     = 16,
  parameter int ADDR_W      = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COORD_W-1:0]    font_width,
  input  logic [COORD_W-1:0]    font_height,
  input  logic [COORD_W-1:0]    x_offset,
  input  logic [COORD_W-1:0]    y_offset,
  input  logic [FONT_IDX_W-1:0] font_index,
  input  logic [CHARS_BITS-1:0] char_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  out_err
);

  localparam int DW    = COORD_W + CHAR_H_BITS;
  localparam int CNT_W = $clog2(DW);
  localparam logic [DW-1:0] MAX_X = DW'((1 << CHAR_W_BITS) - 1);
  localparam logic [DW-1:0] MAX_Y = DW'((1 << CHAR_H_BITS) - 1);

  typedef enum logic [1:0] {IDLE, SETUP, DIV, DONE} state_t;

  state_t                 state;
  logic [COORD_W-1:0]     fw_q, fh_q, x_q, y_q;
  logic [FONT_IDX_W-1:0]  fi_q;
  logic [CHARS_BITS-1:0]  cc_q;
  logic [DW-1:0]          dq;
  logic [COORD_W-1:0]     rem, dsr;
  logic                   byp;
  logic [1:0]             phase;
  logic [CNT_W-1:0]       cnt;
  logic [CHAR_W_BITS-1:0] sx_q;

  logic [COORD_W:0]       rem_sh;
  logic                   ge;
  logic [COORD_W-1:0]     rem_nx;
  logic [DW-1:0]          q_nx, xl_mul, y_mul;
  logic                   sy_clip;
  logic [CHAR_H_BITS-1:0] sy_fin;
  logic [ADDR_W-1:0]      addr_fin;

  assign in_ready = (state == IDLE);

  // One restoring step: dq shifts dividend bits out of the top and quotient bits in
  // at the bottom; a zero divisor forces every quotient bit to 0.
  assign rem_sh  = {rem, dq[DW-1]};
  assign ge      = !byp && (rem_sh >= {1'b0, dsr});
  assign rem_nx  = ge ? COORD_W'(rem_sh - {1'b0, dsr}) : rem_sh[COORD_W-1:0];
  assign q_nx    = {dq[DW-2:0], ge};

  assign xl_mul  = DW'(rem_nx) * MAX_X;
  assign y_mul   = DW'(y_q) * MAX_Y;
  assign sy_clip = (q_nx > MAX_Y);
  assign sy_fin  = sy_clip ? {CHAR_H_BITS{1'b1}} : q_nx[CHAR_H_BITS-1:0];

  assign addr_fin = (ADDR_W'(fi_q) << (CHARS_BITS + CHAR_H_BITS + CHAR_W_BITS))
                  + (ADDR_W'(cc_q) << (CHAR_H_BITS + CHAR_W_BITS))
                  + (ADDR_W'(sy_fin) << CHAR_W_BITS)
                  + ADDR_W'(sx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fw_q      <= '0;
      fh_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      fi_q      <= '0;
      cc_q      <= '0;
      dq        <= '0;
      rem       <= '0;
      dsr       <= '0;
      byp       <= 1'b0;
      phase     <= '0;
      cnt       <= '0;
      sx_q      <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            fw_q  <= font_width;
            fh_q  <= font_height;
            x_q   <= x_offset;
            y_q   <= y_offset;
            fi_q  <= font_index;
            cc_q  <= char_code;
            state <= SETUP;
          end
        end
        SETUP: begin
          if ((fw_q == '0) || (fh_q == '0)) begin
            out_addr  <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            dq    <= DW'(x_q);
            rem   <= '0;
            dsr   <= fw_q;
            byp   <= 1'b0;
            phase <= 2'd0;
            cnt   <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          rem <= rem_nx;
          dq  <= q_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DW - 1)) begin
            // Phase boundary: harvest this division's result and load the next one.
            cnt <= '0;
            rem <= '0;
            case (phase)
              2'd0: begin
                dq    <= xl_mul;
                dsr   <= fw_q - 1'b1;
                byp   <= (fw_q == COORD_W'(1));
                phase <= 2'd1;
              end
              2'd1: begin
                sx_q  <= q_nx[CHAR_W_BITS-1:0];
                dq    <= y_mul;
                dsr   <= fh_q - 1'b1;
                byp   <= (fh_q == COORD_W'(1));
                phase <= 2'd2;
              end
              default: begin
                out_addr  <= addr_fin;
                out_err   <= sy_clip;
                out_valid <= 1'b1;
                state     <= DONE;
              end
            endcase
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_addr_gen.sv
// Randomized and directed bench for glyph_addr_gen against an arithmetic reference model.
module tb_glyph_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] font_width = '0, font_height = '0, x_offset = '0, y_offset = '0;
  logic [7:0]  font_index = '0, char_code = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [29:0] out_addr;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  glyph_addr_gen dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .font_width(font_width), .font_height(font_height),
    .x_offset(x_offset), .y_offset(y_offset),
    .font_index(font_index), .char_code(char_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_err(out_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input longint fw, fh, x, y, fi, cc,
                                output longint addr, output longint err, output longint lat);
    longint xl, sx, sy;
    if (fw == 0 || fh == 0) begin
      addr = 0; err = 1; lat = 2;
      return;
    end
    lat = 3 * 23 + 2;
    err = 0;
    xl  = x % fw;
    sx  = (fw == 1) ? 0 : (xl * 63) / (fw - 1);
    sy  = (fh == 1) ? 0 : (y * 127) / (fh - 1);
    if (sy > 127) begin
      sy = 127; err = 1;
    end
    addr = (fi * 2097152 + cc * 8192 + sy * 64 + sx) % 1073741824;
  endfunction

  // Issue one request, measure latency (accept edge counts as edge 1), check result,
  // hold it for 'hold' cycles with stray in_valid pulses, then optionally release it.
  task automatic do_req(input longint fw, fh, x, y, fi, cc, input int hold, input bit release_it);
    longint ea, ee, el;
    int n;
    model(fw, fh, x, y, fi, cc, ea, ee, el);
    @(negedge clk);
    font_width = 16'(fw); font_height = 16'(fh); x_offset = 16'(x); y_offset = 16'(y);
    font_index = 8'(fi); char_code = 8'(cc); in_valid = 1'b1;
    check("ready_idle", in_ready, 1);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    font_width = 16'($urandom); font_height = 16'($urandom);
    x_offset = 16'($urandom); y_offset = 16'($urandom);
    font_index = 8'($urandom); char_code = 8'($urandom);
    check("ready_busy", in_ready, 0);
    while (!out_valid && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, el);
    check("addr", out_addr, ea);
    check("err", out_err, ee);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_addr", out_addr, ea);
      check("hold_err", out_err, ee);
      check("hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    if (release_it) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_ready", in_ready, 1);
    end
  endtask

  initial begin
    longint fw, fh, y;
    int sel;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_addr", out_addr, 0);
    check("rst_err", out_err, 0);
    check("rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(32, 64, 40, 63, 2, 'h41, 0, 1);
    check("t1_const", out_addr, 4734928);
    do_req(0, 77, 9, 9, 5, 5, 2, 1);
    do_req(1, 1, 5, 0, 0, 3, 0, 1);
    do_req(64, 64, 0, 100, 0, 0, 1, 1);
    do_req(32, 64, 40, 63, 2, 'h41, 10, 1);
    do_req(1000, 0, 3, 3, 1, 1, 0, 1);
    do_req(65535, 65535, 65535, 65535, 255, 255, 0, 1);

    // Reset while a result is held: outputs clear immediately.
    do_req(32, 64, 40, 63, 2, 'h41, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", out_valid, 0);
    check("rst_done_addr", out_addr, 0);
    check("rst_done_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-division, then the same request must reproduce its result.
    @(negedge clk);
    font_width = 16'd32; font_height = 16'd64; x_offset = 16'd40; y_offset = 16'd63;
    font_index = 8'd2; char_code = 8'h41; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_div_valid", out_valid, 0);
    check("rst_div_addr", out_addr, 0);
    check("rst_div_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(32, 64, 40, 63, 2, 'h41, 0, 1);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       fw = 0;
        1:       fw = 1;
        2, 3, 4: fw = $urandom_range(2, 80);
        default: fw = $urandom_range(1, 65535);
      endcase
      sel = $urandom_range(0, 9);
      case (sel)
        0:       fh = (t % 3 == 0) ? 0 : 1;
        1, 2, 3: fh = $urandom_range(2, 130);
        default: fh = $urandom_range(1, 65535);
      endcase
      y = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(0, int'(fh) + 2))
                                      : longint'($urandom_range(0, 65535));
      if (y > 65535) y = 65535;
      do_req(fw, fh, $urandom_range(0, 65535), y, $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 3), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
